// File: rtl/instr_reg_scheduler_if.sv
// Bus between instruction producers/consumer and instr_reg_scheduler.
// master: producers/consumer side; slave: the scheduler.
interface instr_reg_scheduler_if #(
  parameter int AW    = 5,
  parameter int OPC_W = 4,
  parameter int OPD_W = 32
);
  logic [1:0]              req_valid;
  logic [OPC_W-1:0]        req0_opcode;
  logic [OPC_W-1:0]        req1_opcode;
  logic signed [OPD_W-1:0] req0_op_a;
  logic signed [OPD_W-1:0] req1_op_a;
  logic signed [OPD_W-1:0] req0_op_b;
  logic signed [OPD_W-1:0] req1_op_b;
  logic [1:0]              req_ready;
  logic                    flush;
  logic                    rd_pop;
  logic                    load_en;
  logic [AW-1:0]           write_pointer;
  logic [OPC_W-1:0]        opcode;
  logic signed [OPD_W-1:0] operand_a;
  logic signed [OPD_W-1:0] operand_b;
  logic [AW-1:0]           read_pointer;
  logic                    rd_valid;
  logic [AW:0]             occupancy;

  modport master (
    output req_valid, req0_opcode, req1_opcode, req0_op_a, req1_op_a,
           req0_op_b, req1_op_b, flush, rd_pop,
    input  req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
           read_pointer, rd_valid, occupancy
  );

  modport slave (
    input  req_valid, req0_opcode, req1_opcode, req0_op_a, req1_op_a,
           req0_op_b, req1_op_b, flush, rd_pop,
    output req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
           read_pointer, rd_valid, occupancy
  );
endinterface

// File: rtl/instr_reg_scheduler.sv
// Round-robin write arbiter and FIFO read sequencer that turns the 32-entry
// instruction register into a circular instruction queue.
//
// state    | meaning
// ST_INIT  | post-reset settle, 2 cycles, no grants
// ST_RUN   | normal arbitration, commit and pop
// ST_FLUSH | one cycle after a flush, no grants
module instr_reg_scheduler #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int OPC_W = 4,
  parameter int OPD_W = 32
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  instr_reg_scheduler_if.slave bus
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

  localparam logic [1:0] INIT_LOAD = 2'd1;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_init_cnt;
  logic                    r_prio;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_wp_out;
  logic [AW-1:0]           r_rd_ptr;
  logic                    r_load_en;
  logic                    r_rd_valid;
  logic [AW:0]             r_occ;
  logic [OPC_W-1:0]        r_opcode;
  logic signed [OPD_W-1:0] r_op_a;
  logic signed [OPD_W-1:0] r_op_b;

  logic [AW+1:0]           w_fill;
  logic                    w_full;
  logic                    w_can_grant;
  logic [1:0]              w_grant;
  logic                    w_xfer;
  logic                    w_flush;
  logic                    w_pop;
  logic [AW:0]             w_occ_nxt;

  // Fill counts the in-flight write so a grant never overruns the register.
  assign w_fill      = {1'b0, r_occ} + (AW+2)'(r_load_en);
  assign w_full      = (w_fill == (AW+2)'(DEPTH));
  assign w_can_grant = (r_state == ST_RUN) && !bus.flush && !w_full;
  assign w_xfer      = |w_grant;
  assign w_flush     = (r_state == ST_RUN) && bus.flush;
  assign w_pop       = bus.rd_pop && r_rd_valid && !w_flush;
  assign w_occ_nxt   = r_occ + (AW+1)'(r_load_en) - (AW+1)'(w_pop);

  // Round-robin grant: sole requester wins, ties go to the priority holder.
  always_comb begin
    w_grant = 2'b00;
    if (w_can_grant) begin
      if (bus.req_valid == 2'b11) w_grant = r_prio ? 2'b10 : 2'b01;
      else                        w_grant = bus.req_valid;
    end
  end

  // State register and INIT down-counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= INIT_LOAD;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT && r_init_cnt != 2'd0) r_init_cnt <= r_init_cnt - 2'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_INIT:  if (r_init_cnt == 2'd0) w_state_nxt = ST_RUN;
      ST_RUN:   if (bus.flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Write-port registers, pointers and occupancy; flush drops the in-flight write.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prio     <= 1'b0;
      r_wr_ptr   <= '0;
      r_wp_out   <= '0;
      r_rd_ptr   <= '0;
      r_load_en  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_occ      <= '0;
      r_opcode   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
    end else if (w_flush) begin
      r_prio     <= 1'b0;
      r_wr_ptr   <= '0;
      r_wp_out   <= '0;
      r_rd_ptr   <= '0;
      r_load_en  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_occ      <= '0;
    end else begin
      r_load_en <= w_xfer;
      if (w_xfer) begin
        r_wp_out <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_prio   <= w_grant[0];
        if (w_grant[0]) begin
          r_opcode <= bus.req0_opcode;
          r_op_a   <= bus.req0_op_a;
          r_op_b   <= bus.req0_op_b;
        end else begin
          r_opcode <= bus.req1_opcode;
          r_op_a   <= bus.req1_op_a;
          r_op_b   <= bus.req1_op_b;
        end
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ      <= w_occ_nxt;
      r_rd_valid <= (w_occ_nxt != '0);
    end
  end

  assign bus.req_ready     = w_grant;
  assign bus.load_en       = r_load_en;
  assign bus.write_pointer = r_wp_out;
  assign bus.opcode        = r_opcode;
  assign bus.operand_a     = r_op_a;
  assign bus.operand_b     = r_op_b;
  assign bus.read_pointer  = r_rd_ptr;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.occupancy     = r_occ;

endmodule
